// File: rtl/i2si_pkg.sv
// Shared constants and types for the i2si receive path.
package i2si_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 6;

  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

  typedef enum logic {
    SYNC,
    RUN
  } state_e;

endpackage

// File: rtl/i2si_sync_edge.sv
// Two-flop synchroniser for one asynchronous I2S pin.
// With RISE_EN set, it also registers the previous value and flags rising edges.
module i2si_sync_edge #(
  parameter bit RISE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

  generate
    if (RISE_EN) begin : g_rise
      logic prev_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= sync_q;
        end
      end

      assign rise_o = sync_q & ~prev_q;
    end else begin : g_no_rise
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i2si_rx_deser.sv
// I2S serial-to-parallel front end: oversamples SCK/WS/SD and hands MSB-justified words to the FIFO.
// Define I2SI_MONO_EN to present only left-channel words (right words are discarded silently).
module i2si_rx_deser
  import i2si_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  i2s_sck,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_chan,
  output logic                  out_rts,
  input  logic                  out_rtr,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic sck_rise, ws_s, sd_s;
  logic unused_sck_s, unused_ws_rise, unused_sd_rise;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, word, data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                  ws_prev_q, ws_prev_d;
  logic                  chan_q, chan_d, rts_q, rts_d, ovf_q, ovf_d;
  logic                  ws_change, word_done, word_keep, word_chan, ovf_set;

  i2si_sync_edge #(.RISE_EN(1'b1)) u_sck (
    .clk(clk), .rst(rst), .d_i(i2s_sck), .sync_o(unused_sck_s), .rise_o(sck_rise)
  );
  i2si_sync_edge #(.RISE_EN(1'b0)) u_ws (
    .clk(clk), .rst(rst), .d_i(i2s_ws), .sync_o(ws_s), .rise_o(unused_ws_rise)
  );
  i2si_sync_edge #(.RISE_EN(1'b0)) u_sd (
    .clk(clk), .rst(rst), .d_i(i2s_sd), .sync_o(sd_s), .rise_o(unused_sd_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SYNC;
      shift_q   <= '0;
      cnt_q     <= '0;
      ws_prev_q <= 1'b0;
      data_q    <= '0;
      chan_q    <= 1'b0;
      rts_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ws_prev_q <= ws_prev_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      rts_q     <= rts_d;
      ovf_q     <= ovf_d;
    end
  end

  // Philips timing: the bit sampled on the WS-change rise is the LSB of the outgoing word.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ws_prev_d = ws_prev_q;
    word_done = 1'b0;
    word      = shift_q;
    ws_change = sck_rise && (ws_s != ws_prev_q);
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    if (sck_rise) begin
      ws_prev_d = ws_s;
    end

    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (int'(cnt_q) == DATA_WIDTH - 1 - i) begin
        word[i] = sd_s;
      end
    end

    if (!en) begin
      state_d = SYNC;
      shift_d = '0;
      cnt_d   = '0;
    end else if (state_q == SYNC) begin
      if (ws_change) begin
        state_d = RUN;
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (sck_rise) begin
      if (ws_change) begin
        word_done = 1'b1;
        shift_d   = '0;
        cnt_d     = '0;
      end else begin
        shift_d = word;
        cnt_d   = cnt_inc;
      end
    end
  end

`ifdef I2SI_MONO_EN
  assign word_keep = word_done && (ws_prev_q == CHAN_LEFT);
  assign word_chan = CHAN_LEFT;
`else
  assign word_keep = word_done;
  assign word_chan = ws_prev_q;
`endif

  // A word completing while the previous one is still held is dropped, never overwritten.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    rts_d   = rts_q;
    ovf_d   = ovf_q;
    ovf_set = 1'b0;

    if (rts_q && out_rtr) begin
      rts_d = 1'b0;
    end

    if (word_keep) begin
      if (!rts_q || out_rtr) begin
        data_d = word;
        chan_d = word_chan;
        rts_d  = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end

    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  assign out_data = data_q;
  assign out_chan = chan_q;
  assign out_rts  = rts_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_i2si_rx_deser.sv
// Scoreboard bench for i2si_rx_deser: drives Philips-timed I2S slots and predicts the
// MSB-justified words from the slot contents; a monitor compares every handshake transfer.
module tb_i2si_rx_deser;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst, en, i2sSck, i2sWs, i2sSd, ovfClr;
  logic [7:0] outData;
  logic       outChan, outRts, outRtr, overflow;
  logic       rtrDrive, fifoMode;
  int         fifoCount;
  int         checks, errors;
  logic [8:0] expQ[$];
  bit         synced;
  logic       curChan;

  assign outRtr = fifoMode ? (fifoCount < 4) : rtrDrive;

  always #5 clk = ~clk;

  // Stand-in for the downstream FIFO: four entries, never read while fifoMode is set.
  always @(posedge clk) begin
    if (fifoMode && outRts && outRtr) fifoCount <= fifoCount + 1;
  end

  i2si_rx_deser dut (
    .clk(clk), .rst(rst), .en(en),
    .i2s_sck(i2sSck), .i2s_ws(i2sWs), .i2s_sd(i2sSd),
    .out_data(outData), .out_chan(outChan), .out_rts(outRts), .out_rtr(outRtr),
    .overflow(overflow), .ovf_clr(ovfClr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic ws, input logic sd);
    i2sWs = ws;
    i2sSd = sd;
    waitClks(HALF);
    i2sSck = 1'b1;
    waitClks(HALF);
    i2sSck = 1'b0;
  endtask

  // Top DATA_WIDTH bits of the slot, zero-filled when the slot is shorter.
  function automatic logic [7:0] justify(input int n, input logic [127:0] val);
    if (n >= 8) return 8'(val >> (n - 8));
    return 8'(val << (8 - n));
  endfunction

  // One channel slot of n bits; the LSB goes out with WS already flipped to the next channel.
  task automatic applyStimulus(input int n, input logic [127:0] val, input bit keep,
                               input int glitchAt, input int stopAt);
    for (int i = n - 1; i >= 1; i--) begin
      if (n - 1 - i == stopAt) return;
      if (n - 1 - i == glitchAt) begin
        en = 1'b0;
        waitClks(6);
        en = 1'b1;
        synced = 1'b0;
      end
      sendBit(curChan, val[i]);
    end
    if (!synced) synced = 1'b1;
    else if (keep) expQ.push_back({curChan, justify(n, val)});
    sendBit(~curChan, val[0]);
    curChan = ~curChan;
  endtask

  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (!rst && outRts && outRtr) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL word: got unexpected %h chan %0d, expected no word", outData, outChan);
      end else begin
        e = expQ.pop_front();
        checkOutput("word", {23'd0, outChan, outData}, {23'd0, e});
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] v;
    int           n;
    int           budget;
    rst = 1'b1; en = 1'b1; ovfClr = 1'b0; rtrDrive = 1'b1; fifoMode = 1'b0; fifoCount = 0;
    i2sSck = 1'b0; i2sWs = 1'b0; i2sSd = 1'b0; checks = 0; errors = 0;
    curChan = 1'b0; synced = 1'b0;
    waitClks(3);
    checkOutput("reset_data", outData, 0);
    checkOutput("reset_chan", outChan, 0);
    checkOutput("reset_rts", outRts, 0);
    checkOutput("reset_ovf", overflow, 0);
    rst = 1'b0;
    waitClks(3);

    $display("[TB] stereo frame");
    applyStimulus(8, 128'hC3, 1, -1, -1);
    applyStimulus(8, 128'hA5, 1, -1, -1);
    applyStimulus(8, 128'h3C, 1, -1, -1);
    waitClks(12);
    checkOutput("rts_idle", outRts, 0);
    checkOutput("ovf_quiet", overflow, 0);

    $display("[TB] long and short slots");
    applyStimulus(16, 128'h1234, 1, -1, -1);
    applyStimulus(16, 128'hBEEF, 1, -1, -1);
    applyStimulus(5, 128'h16, 1, -1, -1);
    applyStimulus(5, 128'h0B, 1, -1, -1);
    for (int k = 0; k < 2; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(70, v, 1, -1, -1);
    end

    $display("[TB] random slots");
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(5, 16);
      v = 128'($urandom);
      applyStimulus(n, v, 1, -1, -1);
    end
    waitClks(20);

    $display("[TB] backpressure");
    rtrDrive = 1'b0;
    applyStimulus(8, 128'h11, 1, -1, -1);
    applyStimulus(8, 128'h22, 0, -1, -1);
    waitClks(10);
    checkOutput("stall_ovf", overflow, 1);
    checkOutput("stall_data", outData, 8'h11);
    checkOutput("stall_rts", outRts, 1);
    rtrDrive = 1'b1;
    waitClks(4);
    checkOutput("stall_drain_rts", outRts, 0);
    checkOutput("ovf_sticky", overflow, 1);
    ovfClr = 1'b1;
    waitClks(1);
    ovfClr = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);

    $display("[TB] enable dropped mid-word");
    applyStimulus(8, 128'($urandom), 1, 3, -1);
    applyStimulus(8, 128'h5A, 1, -1, -1);
    applyStimulus(8, 128'hC6, 1, -1, -1);
    waitClks(12);

    $display("[TB] reset mid-word");
    rtrDrive = 1'b0;
    applyStimulus(8, 128'h77, 1, -1, -1);
    applyStimulus(8, 128'h99, 1, -1, 3);
    checkOutput("held_data", outData, 8'h77);
    rst = 1'b1;
    #1;
    checkOutput("rst_data", outData, 0);
    checkOutput("rst_chan", outChan, 0);
    checkOutput("rst_rts", outRts, 0);
    checkOutput("rst_ovf", overflow, 0);
    expQ.delete();
    i2sSck = 1'b0; i2sWs = 1'b0; i2sSd = 1'b0;
    curChan = 1'b0; synced = 1'b0; rtrDrive = 1'b1;
    waitClks(4);
    rst = 1'b0;
    waitClks(3);
    applyStimulus(8, 128'hE7, 1, -1, -1);
    applyStimulus(8, 128'h42, 1, -1, -1);
    applyStimulus(8, 128'h81, 1, -1, -1);
    waitClks(20);

    $display("[TB] stream into a stalled fifo");
    fifoMode = 1'b1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(8, 128'($urandom_range(0, 255)), k < 5, -1, -1);
    end
    waitClks(20);
    checkOutput("fifo_fill", fifoCount, 4);
    checkOutput("fifo_ovf", overflow, 1);
    checkOutput("fifo_held_rts", outRts, 1);
    fifoMode = 1'b0;
    rtrDrive = 1'b1;

    budget = 200;
    while (expQ.size() != 0 && budget > 0) begin
      waitClks(1);
      budget--;
    end
    checkOutput("queue_empty", 32'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
